// File: rtl/imem_port_mux.sv
// Shares one fixed-latency instruction memory among N_CPUS fetch ports.
// Optional IMEM_PORT_MUX_ERR_CHECK_EN adds a sticky handshake/grant error flag.
module imem_port_mux #(
    parameter int N_CPUS      = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CPUS-1:0]        cpu_req_valid,
    input  logic [N_CPUS*ADDR_W-1:0] cpu_req_addr,
    output logic [N_CPUS-1:0]        cpu_req_ready,
    output logic [N_CPUS-1:0]        cpu_rsp_valid,
    output logic [DATA_W-1:0]        cpu_rsp_data,
    output logic [N_CPUS-1:0]        arb_req,
    input  logic [N_CPUS-1:0]        arb_gnt,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_rd_addr,
    input  logic [DATA_W-1:0]        mem_rd_data,
    output logic                     err
);

    localparam int ID_W = (N_CPUS > 1) ? $clog2(N_CPUS) : 1;

    logic [N_CPUS-1:0] outstanding;
    logic [N_CPUS-1:0] masked;
    logic [N_CPUS-1:0] sel;
    logic [ID_W-1:0]   sel_id;
    logic [ADDR_W-1:0] sel_addr;
    logic              hit;
    logic              go;

    logic              tag_v  [MEM_LATENCY];
    logic [ID_W-1:0]   tag_id [MEM_LATENCY];
    logic              tail_v;
    logic [ID_W-1:0]   tail_id;
    logic [N_CPUS-1:0] rsp_clr;

    assign arb_req = cpu_req_valid & ~outstanding;
    assign masked  = arb_gnt & arb_req;

    // Lowest-index requesting grant wins if the arbiter misbehaves.
    always_comb begin
        sel      = '0;
        sel_id   = '0;
        sel_addr = '0;
        hit      = 1'b0;
        for (int i = 0; i < N_CPUS; i++) begin
            if (masked[i] && !hit) begin
                hit      = 1'b1;
                sel[i]   = 1'b1;
                sel_id   = ID_W'(i);
                sel_addr = cpu_req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign go            = hit & ~rst;
    assign cpu_req_ready = go ? sel : '0;
    assign mem_rd_en     = go;
    assign mem_rd_addr   = go ? sel_addr : '0;

    assign tail_v  = tag_v[MEM_LATENCY-1];
    assign tail_id = tag_id[MEM_LATENCY-1];
    assign rsp_clr = tail_v ? (N_CPUS'(1) << tail_id) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[0]  <= go;
            tag_id[0] <= sel_id;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding   <= '0;
            cpu_rsp_valid <= '0;
            cpu_rsp_data  <= '0;
        end else begin
            outstanding   <= (outstanding & ~rsp_clr) | cpu_req_ready;
            cpu_rsp_valid <= rsp_clr;
            if (tail_v)
                cpu_rsp_data <= mem_rd_data;
        end
    end

`ifdef IMEM_PORT_MUX_ERR_CHECK_EN
    logic                     err_q;
    logic [N_CPUS-1:0]        prev_v;
    logic [N_CPUS-1:0]        prev_r;
    logic [N_CPUS*ADDR_W-1:0] prev_a;
    logic                     hold_bad;
    logic                     multi;
    logic                     stray;

    always_comb begin
        hold_bad = 1'b0;
        for (int i = 0; i < N_CPUS; i++) begin
            if (prev_v[i] && !prev_r[i] &&
                (!cpu_req_valid[i] ||
                 cpu_req_addr[i*ADDR_W +: ADDR_W] != prev_a[i*ADDR_W +: ADDR_W]))
                hold_bad = 1'b1;
        end
    end

    assign multi = |(arb_gnt & (arb_gnt - N_CPUS'(1)));
    assign stray = |(arb_gnt & ~arb_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= 1'b0;
            prev_v <= '0;
            prev_r <= '0;
            prev_a <= '0;
        end else begin
            err_q  <= err_q | multi | stray | hold_bad;
            prev_v <= cpu_req_valid;
            prev_r <= cpu_req_ready;
            prev_a <= cpu_req_addr;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_port_mux.sv
// Directed bench for imem_port_mux with a 2-cycle memory model.
// Error-flag expectations follow IMEM_PORT_MUX_ERR_CHECK_EN.
module tb_imem_port_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cpu_req_valid;
    logic [95:0] cpu_req_addr;
    logic [2:0]  cpu_req_ready;
    logic [2:0]  cpu_rsp_valid;
    logic [31:0] cpu_rsp_data;
    logic [2:0]  arb_req;
    logic [2:0]  arb_gnt;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic        p1_en, p2_en;
    logic [31:0] p1_a, p2_a;

    always #5 clk = ~clk;

    imem_port_mux dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req_valid(cpu_req_valid),
        .cpu_req_addr (cpu_req_addr),
        .cpu_req_ready(cpu_req_ready),
        .cpu_rsp_valid(cpu_rsp_valid),
        .cpu_rsp_data (cpu_rsp_data),
        .arb_req      (arb_req),
        .arb_gnt      (arb_gnt),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .err          (err)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h40)
            return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h1234, a[15:0]};
    endfunction

    always @(posedge clk) begin
        p1_en <= mem_rd_en;
        p1_a  <= mem_rd_addr;
        p2_en <= p1_en;
        p2_a  <= p1_a;
    end

    assign mem_rd_data = p2_en ? mem_fn(p2_a) : 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [31:0] a);
        cpu_req_addr[i*32 +: 32] = a;
    endtask

`ifdef IMEM_PORT_MUX_ERR_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    initial begin
        p1_en = 1'b0; p2_en = 1'b0; p1_a = '0; p2_a = '0;
        rst = 1'b1;
        cpu_req_valid = 3'b010;
        cpu_req_addr  = '0;
        arb_gnt       = 3'b010;
        tick();
        tick();
        chk("rst_ready", 64'(cpu_req_ready), 64'h0);
        chk("rst_en", 64'(mem_rd_en), 64'h0);
        chk("rst_addr", 64'(mem_rd_addr), 64'h0);
        chk("rst_rspv", 64'(cpu_rsp_valid), 64'h0);
        chk("rst_rspd", 64'(cpu_rsp_data), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        cpu_req_valid = 3'b000;
        arb_gnt = 3'b000;
        rst = 1'b0;
        tick();

        // single fetch
        cpu_req_valid = 3'b010; set_addr(1, 32'h40); arb_gnt = 3'b010;
        #1;
        chk("sf_req", 64'(arb_req), 64'h2);
        chk("sf_ready", 64'(cpu_req_ready), 64'h2);
        chk("sf_en", 64'(mem_rd_en), 64'h1);
        chk("sf_addr", 64'(mem_rd_addr), 64'h40);
        tick();
        cpu_req_valid = 3'b000; arb_gnt = 3'b000;
        #1;
        chk("sf_rsp0", 64'(cpu_rsp_valid), 64'h0);
        tick();
        chk("sf_rsp1", 64'(cpu_rsp_valid), 64'h0);
        tick();
        chk("sf_rspv", 64'(cpu_rsp_valid), 64'h2);
        chk("sf_rspd", 64'(cpu_rsp_data), 64'hDEAD_BEEF);
        tick();
        chk("sf_pulse", 64'(cpu_rsp_valid), 64'h0);
        chk("sf_hold", 64'(cpu_rsp_data), 64'hDEAD_BEEF);

        // back-to-back
        set_addr(0, 32'h0); set_addr(1, 32'h4); set_addr(2, 32'h8);
        cpu_req_valid = 3'b111; arb_gnt = 3'b001;
        #1;
        chk("bb_addr0", 64'(mem_rd_addr), 64'h0);
        tick();
        cpu_req_valid = 3'b110; arb_gnt = 3'b010;
        #1;
        chk("bb_req1", 64'(arb_req), 64'h6);
        chk("bb_addr1", 64'(mem_rd_addr), 64'h4);
        tick();
        cpu_req_valid = 3'b100; arb_gnt = 3'b100;
        #1;
        chk("bb_addr2", 64'(mem_rd_addr), 64'h8);
        tick();
        cpu_req_valid = 3'b000; arb_gnt = 3'b000;
        chk("bb_v0", 64'(cpu_rsp_valid), 64'h1);
        chk("bb_d0", 64'(cpu_rsp_data), 64'h1234_0000);
        tick();
        chk("bb_v1", 64'(cpu_rsp_valid), 64'h2);
        chk("bb_d1", 64'(cpu_rsp_data), 64'h1230_0004);
        tick();
        chk("bb_v2", 64'(cpu_rsp_valid), 64'h4);
        chk("bb_d2", 64'(cpu_rsp_data), 64'h123C_0008);
        tick();
        chk("bb_end", 64'(cpu_rsp_valid), 64'h0);

        // one outstanding per CPU
        cpu_req_valid = 3'b001; set_addr(0, 32'h10); arb_gnt = 3'b001;
        tick();
        arb_gnt = 3'b000;
        #1;
        chk("oo_req_a", 64'(arb_req), 64'h0);
        tick();
        chk("oo_req_b", 64'(arb_req), 64'h0);
        tick();
        chk("oo_rspv", 64'(cpu_rsp_valid), 64'h1);
        chk("oo_rspd", 64'(cpu_rsp_data), 64'h1224_0010);
        chk("oo_req_c", 64'(arb_req), 64'h1);
        arb_gnt = 3'b001;
        #1;
        chk("oo_ready", 64'(cpu_req_ready), 64'h1);
        chk("oo_en", 64'(mem_rd_en), 64'h1);
        tick();
        cpu_req_valid = 3'b000; arb_gnt = 3'b000;
        tick();
        chk("oo_gap", 64'(cpu_rsp_valid), 64'h0);
        tick();
        chk("oo_rspv2", 64'(cpu_rsp_valid), 64'h1);
        chk("oo_rspd2", 64'(cpu_rsp_data), 64'h1224_0010);
        tick();

        // response and accept on the same edge
        cpu_req_valid = 3'b100; set_addr(2, 32'h20); arb_gnt = 3'b100;
        tick();
        cpu_req_valid = 3'b000; arb_gnt = 3'b000;
        tick();
        cpu_req_valid = 3'b001; set_addr(0, 32'h30); arb_gnt = 3'b001;
        #1;
        chk("sim_ready", 64'(cpu_req_ready), 64'h1);
        tick();
        cpu_req_valid = 3'b000; arb_gnt = 3'b000;
        chk("sim_v2", 64'(cpu_rsp_valid), 64'h4);
        chk("sim_d2", 64'(cpu_rsp_data), 64'h1214_0020);
        tick();
        chk("sim_gap", 64'(cpu_rsp_valid), 64'h0);
        tick();
        chk("sim_v0", 64'(cpu_rsp_valid), 64'h1);
        chk("sim_d0", 64'(cpu_rsp_data), 64'h1204_0030);
        tick();

        // grant rules
        cpu_req_valid = 3'b011; set_addr(0, 32'h50); set_addr(1, 32'h60);
        arb_gnt = 3'b100;
        #1;
        chk("gr_stray_rdy", 64'(cpu_req_ready), 64'h0);
        chk("gr_stray_en", 64'(mem_rd_en), 64'h0);
        arb_gnt = 3'b011;
        #1;
        chk("gr_multi_rdy", 64'(cpu_req_ready), 64'h1);
        chk("gr_multi_addr", 64'(mem_rd_addr), 64'h50);
        tick();
        cpu_req_valid = 3'b000; arb_gnt = 3'b000;
        chk("gr_err", 64'(err), 64'(ERR_EXP));
        tick();
        chk("gr_err_hold", 64'(err), 64'(ERR_EXP));
        tick();
        chk("gr_rspv", 64'(cpu_rsp_valid), 64'h1);
        chk("gr_rspd", 64'(cpu_rsp_data), 64'h1264_0050);
        tick();

        // reset mid-flight
        cpu_req_valid = 3'b010; set_addr(1, 32'h70); arb_gnt = 3'b010;
        tick();
        cpu_req_valid = 3'b000; arb_gnt = 3'b000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cpu_req_valid = 3'b010;
        #1;
        chk("rm_req", 64'(arb_req), 64'h2);
        chk("rm_err", 64'(err), 64'h0);
        chk("rm_rspd", 64'(cpu_rsp_data), 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rm_norsp", 64'(cpu_rsp_valid), 64'h0);
        end
        chk("rm_req_end", 64'(arb_req), 64'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
